// File: rtl/jtmx5k_gfx_romslot.sv
// Graphics ROM slot: one-entry tagged cache in front of an SDRAM controller
// read port. Misses are forwarded through a req/ack/data-ready handshake, and
// rom_ok flags that rom_data belongs to the address currently presented.
module jtmx5k_gfx_romslot #(
  parameter int             AW     = 18,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = 22'h0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [15:0]    rom_data,
  output logic           rom_ok,
  output logic           sdram_req,
  output logic [SDW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           data_rdy,
  input  logic [15:0]    data_read
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_DATA
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_hit;
  logic           w_issue;
  logic           w_store;
  logic           w_req_clr;
  logic [SDW-1:0] w_sdram_addr;

  logic           r_req;
  logic [SDW-1:0] r_sdram_addr;
  logic [15:0]    r_data;
  logic [AW-1:0]  r_tag;
  logic [AW-1:0]  r_pend_addr;
  logic           r_valid;

  // The sum is taken at SDW bits, so an OFFSET near the top of SDRAM wraps
  // around to the bottom instead of carrying out.
  assign w_sdram_addr = OFFSET + SDW'(rom_addr);

  // Hit means the cached word matches the address on the bus right now;
  // rom_cs only gates the ok flag, it never invalidates the entry.
  assign w_hit  = r_valid && (r_tag == rom_addr);
  assign rom_ok = rom_cs && w_hit;

  assign rom_data   = r_data;
  assign sdram_req  = r_req;
  assign sdram_addr = r_sdram_addr;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update together from the values sampled at the edge.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and the one-cycle strobes that drive the datapath.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and turns it into a latch.
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_store     = 1'b0;
    w_req_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rom_cs && !w_hit) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          w_req_clr = 1'b1;
          // Data may come back in the same cycle as the ack; take it then.
          if (data_rdy) begin
            w_store     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (data_rdy) begin
          w_store     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request, address and cache-entry registers. The in-flight address is
  // frozen in r_pend_addr so a moving rom_addr cannot mislabel the data.
  always_ff @(posedge clk) begin
    // NOTE: the cache data and tag are reset along with valid, so rom_data
    // reads as zero after reset rather than a stale word.
    if (rst) begin
      r_req        <= 1'b0;
      r_sdram_addr <= '0;
      r_data       <= '0;
      r_tag        <= '0;
      r_pend_addr  <= '0;
      r_valid      <= 1'b0;
    end else begin
      if (w_issue) begin
        r_req        <= 1'b1;
        r_sdram_addr <= w_sdram_addr;
        r_pend_addr  <= rom_addr;
      end else if (w_req_clr) begin
        r_req <= 1'b0;
      end
      if (w_store) begin
        r_data  <= data_read;
        r_tag   <= r_pend_addr;
        r_valid <= 1'b1;
      end
    end
  end

endmodule
